// File: rtl/lut_add_pkg.sv
// Shared constants, bundle types and FSM states for the matrix-add LUT server.
package lut_add_pkg;

    localparam int unsigned TILES = 4;
    localparam int unsigned LANES = 8;
    localparam int unsigned NLOOK = TILES * LANES;
    localparam int unsigned AW    = 11;
    localparam int unsigned DW    = 11;
    localparam int unsigned IW    = $clog2(NLOOK);
    localparam int unsigned LW    = $clog2(LANES);
    localparam int unsigned SW    = 10;

    typedef logic [TILES-1:0][LANES-1:0][AW-1:0] addr_bundle_t;
    typedef logic [TILES-1:0][LANES-1:0][DW-1:0] data_bundle_t;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        DRAIN = 2'd2,
        RESP  = 2'd3
    } state_t;

endpackage

// File: rtl/lut_rd_tag_pipe.sv
// Valid shift register that follows issued ROM reads and flags when their data is due.
module lut_rd_tag_pipe #(
    parameter int unsigned LAT = 1
) (
    input  logic clk,
    input  logic rst,
    input  logic flush,
    input  logic vld_in,
    output logic cap_strobe
);

    logic [LAT-1:0] sr_q;

    generate
        if (LAT == 1) begin : g_one
            // Single-stage tag register, cleared on flush or reset.
            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    sr_q <= '0;
                end else if (flush) begin
                    sr_q <= '0;
                end else begin
                    sr_q <= vld_in;
                end
            end
        end else begin : g_multi
            // Multi-stage tag shift, cleared on flush or reset.
            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    sr_q <= '0;
                end else if (flush) begin
                    sr_q <= '0;
                end else begin
                    sr_q <= {sr_q[LAT-2:0], vld_in};
                end
            end
        end
    endgenerate

    assign cap_strobe = sr_q[LAT-1];

endmodule

// File: rtl/lut_add_server.sv
// Serves a 32-address LUT request through one shared synchronous ROM port and
// returns all results as a single response bundle.
module lut_add_server
    import lut_add_pkg::*;
#(
    parameter int unsigned ROM_LAT = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             req_valid,
    output logic             req_ready,
    input  addr_bundle_t     req_addr,
    input  logic [4:0]       req_m_bit1,
    input  logic [4:0]       req_m_bit2,
    output logic             resp_valid,
    input  logic             resp_ready,
    output data_bundle_t     resp_data,
    output logic             rom_en,
    output logic [AW-1:0]    rom_addr,
    output logic [SW-1:0]    rom_sel,
    input  logic [DW-1:0]    rom_dout,
    output logic             busy
);

    state_t        state_q, state_d;
    addr_bundle_t  addr_q, addr_d;
    logic [IW-1:0] iss_q, iss_d;
    logic [IW-1:0] cap_q, cap_d;
    logic [IW-1:0] iss_nxt;

    logic          req_ready_d;
    logic          resp_valid_d;
    data_bundle_t  resp_data_d;
    logic          rom_en_d;
    logic [AW-1:0] rom_addr_d;
    logic [SW-1:0] rom_sel_d;
    logic          busy_d;

    logic          accept_c;
    logic          cap_strobe;

    // Tracks outstanding ROM reads; flushed on every new request.
    lut_rd_tag_pipe #(
        .LAT (ROM_LAT)
    ) u_tag_pipe (
        .clk        (clk),
        .rst        (rst),
        .flush      (accept_c),
        .vld_in     (rom_en),
        .cap_strobe (cap_strobe)
    );

    // Next-state, issue/capture indexing and next values of all registered outputs.
    always_comb begin
        state_d      = state_q;
        addr_d       = addr_q;
        iss_d        = iss_q;
        cap_d        = cap_q;
        iss_nxt      = iss_q + IW'(1);
        req_ready_d  = req_ready;
        resp_valid_d = resp_valid;
        resp_data_d  = resp_data;
        rom_en_d     = 1'b0;
        rom_addr_d   = rom_addr;
        rom_sel_d    = rom_sel;
        accept_c     = 1'b0;

        // Returning data lands in the slot after the previous one, in issue order.
        if (cap_strobe && ((state_q == ISSUE) || (state_q == DRAIN))) begin
            resp_data_d[cap_q[IW-1:LW]][cap_q[LW-1:0]] = rom_dout;
            cap_d = cap_q + IW'(1);
        end

        case (state_q)
            IDLE: begin
                if (req_valid) begin
                    accept_c    = 1'b1;
                    state_d     = ISSUE;
                    addr_d      = req_addr;
                    rom_sel_d   = {req_m_bit1, req_m_bit2};
                    iss_d       = '0;
                    cap_d       = '0;
                    req_ready_d = 1'b0;
                    // Lane 0 goes out in the cycle right after acceptance.
                    rom_en_d    = 1'b1;
                    rom_addr_d  = req_addr[0][0];
                end
            end
            ISSUE: begin
                if (iss_q == IW'(NLOOK - 1)) begin
                    state_d = DRAIN;
                end else begin
                    rom_en_d   = 1'b1;
                    iss_d      = iss_nxt;
                    rom_addr_d = addr_q[iss_nxt[IW-1:LW]][iss_nxt[LW-1:0]];
                end
            end
            DRAIN: begin
                if (cap_strobe && (cap_q == IW'(NLOOK - 1))) begin
                    state_d      = RESP;
                    resp_valid_d = 1'b1;
                end
            end
            RESP: begin
                if (resp_ready) begin
                    state_d      = IDLE;
                    resp_valid_d = 1'b0;
                    req_ready_d  = 1'b1;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        busy_d = (state_d != IDLE);
    end

    // State, working registers and registered outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= IDLE;
            addr_q     <= '0;
            iss_q      <= '0;
            cap_q      <= '0;
            req_ready  <= 1'b1;
            resp_valid <= 1'b0;
            resp_data  <= '0;
            rom_en     <= 1'b0;
            rom_addr   <= '0;
            rom_sel    <= '0;
            busy       <= 1'b0;
        end else begin
            state_q    <= state_d;
            addr_q     <= addr_d;
            iss_q      <= iss_d;
            cap_q      <= cap_d;
            req_ready  <= req_ready_d;
            resp_valid <= resp_valid_d;
            resp_data  <= resp_data_d;
            rom_en     <= rom_en_d;
            rom_addr   <= rom_addr_d;
            rom_sel    <= rom_sel_d;
            busy       <= busy_d;
        end
    end

endmodule

// File: tb/tb_lut_add_server.sv
// Directed bench for lut_add_server: ROM_LAT=1 and ROM_LAT=3 instances with ROM models.
module tb_lut_add_server;
    import lut_add_pkg::*;

    localparam logic [DW-1:0] XK   = 11'h155;
    localparam logic [DW-1:0] JUNK = 11'h3C3;

    logic          clk;
    logic          rst;
    logic          req_valid, req_valid3;
    logic          resp_ready, resp_ready3;
    addr_bundle_t  req_addr;
    logic [4:0]    m1, m2;

    logic          req_ready1, resp_valid1, rom_en1, busy1;
    data_bundle_t  resp_data1;
    logic [AW-1:0] rom_addr1;
    logic [SW-1:0] rom_sel1;
    logic [DW-1:0] rom_dout1;

    logic          req_ready3, resp_valid3, rom_en3, busy3;
    data_bundle_t  resp_data3;
    logic [AW-1:0] rom_addr3;
    logic [SW-1:0] rom_sel3;
    logic [DW-1:0] rom_dout3, r3a, r3b;

    int n_checks = 0;
    int n_pass   = 0;

    lut_add_server #(.ROM_LAT(1)) dut1 (
        .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready1),
        .req_addr(req_addr), .req_m_bit1(m1), .req_m_bit2(m2),
        .resp_valid(resp_valid1), .resp_ready(resp_ready), .resp_data(resp_data1),
        .rom_en(rom_en1), .rom_addr(rom_addr1), .rom_sel(rom_sel1),
        .rom_dout(rom_dout1), .busy(busy1)
    );

    lut_add_server #(.ROM_LAT(3)) dut3 (
        .clk(clk), .rst(rst), .req_valid(req_valid3), .req_ready(req_ready3),
        .req_addr(req_addr), .req_m_bit1(m1), .req_m_bit2(m2),
        .resp_valid(resp_valid3), .resp_ready(resp_ready3), .resp_data(resp_data3),
        .rom_en(rom_en3), .rom_addr(rom_addr3), .rom_sel(rom_sel3),
        .rom_dout(rom_dout3), .busy(busy3)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ROM models: contents are addr ^ 11'h155, junk when not enabled.
    always @(posedge clk) rom_dout1 <= rom_en1 ? (rom_addr1 ^ XK) : JUNK;
    always @(posedge clk) begin
        r3a       <= rom_en3 ? (rom_addr3 ^ XK) : JUNK;
        r3b       <= r3a;
        rom_dout3 <= r3b;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic data_bundle_t rom_of(input addr_bundle_t a);
        data_bundle_t e;
        for (int t = 0; t < TILES; t++)
            for (int l = 0; l < LANES; l++)
                e[t][l] = a[t][l] ^ XK;
        return e;
    endfunction

    function automatic addr_bundle_t ramp(input int base, input int step);
        addr_bundle_t a;
        for (int t = 0; t < TILES; t++)
            for (int l = 0; l < LANES; l++)
                a[t][l] = AW'(base + step * (t * LANES + l));
        return a;
    endfunction

    task automatic test_reset();
        rst = 1'b1;
        tick();
        tick();
        n_checks++;
        if (req_ready1 !== 1'b1 || resp_valid1 !== 1'b0 || busy1 !== 1'b0)
            $display("FAIL reset_hs: ready=%b valid=%b busy=%b want 1 0 0", req_ready1, resp_valid1, busy1);
        else n_pass++;
        n_checks++;
        if (rom_en1 !== 1'b0 || rom_addr1 !== '0 || rom_sel1 !== '0)
            $display("FAIL reset_rom: en=%b addr=%h sel=%h want 0 0 0", rom_en1, rom_addr1, rom_sel1);
        else n_pass++;
        n_checks++;
        if (resp_data1 !== '0)
            $display("FAIL reset_data: got %h want 0", resp_data1);
        else n_pass++;
        n_checks++;
        if (req_ready3 !== 1'b1 || busy3 !== 1'b0)
            $display("FAIL reset_lat3: ready=%b busy=%b want 1 0", req_ready3, busy3);
        else n_pass++;
        rst = 1'b0;
        tick();
    endtask

    task automatic test_single();
        addr_bundle_t a;
        data_bundle_t e;
        int lat, bad;
        a = ramp(0, 1);
        e = rom_of(a);
        req_addr = a; m1 = 5'h01; m2 = 5'h02;
        req_valid = 1'b1;
        tick();
        req_valid = 1'b0;
        lat = -1; bad = 0;
        for (int c = 0; c < 60; c++) begin
            if (c < 32 && (rom_en1 !== 1'b1 || rom_addr1 !== AW'(c))) bad++;
            if (c == 32 && rom_en1 !== 1'b0) bad++;
            if (resp_valid1) begin lat = c; break; end
            tick();
        end
        n_checks++;
        if (bad != 0) $display("FAIL single_sweep: %0d bad issue cycles want 0", bad);
        else n_pass++;
        n_checks++;
        if (lat != 33) $display("FAIL single_latency: got %0d want 33", lat);
        else n_pass++;
        n_checks++;
        if (resp_data1 !== e) $display("FAIL single_data: got %h want %h", resp_data1, e);
        else n_pass++;
        n_checks++;
        if (rom_sel1 !== 10'h022) $display("FAIL single_sel: got %h want 022", rom_sel1);
        else n_pass++;
        resp_ready = 1'b1;
        tick();
        resp_ready = 1'b0;
        n_checks++;
        if (req_ready1 !== 1'b1 || resp_valid1 !== 1'b0 || busy1 !== 1'b0)
            $display("FAIL single_done: ready=%b valid=%b busy=%b want 1 0 0", req_ready1, resp_valid1, busy1);
        else n_pass++;
    endtask

    task automatic test_backpressure();
        addr_bundle_t a;
        data_bundle_t e;
        int lat, bad;
        a = ramp(32'h400, 3);
        e = rom_of(a);
        req_addr = a;
        req_valid = 1'b1;
        tick();
        req_valid = 1'b0;
        lat = -1;
        for (int c = 0; c < 60; c++) begin
            if (resp_valid1) begin lat = c; break; end
            tick();
        end
        n_checks++;
        if (lat != 33) $display("FAIL bp_latency: got %0d want 33", lat);
        else n_pass++;
        bad = 0;
        for (int c = 0; c < 10; c++) begin
            if (resp_data1 !== e || resp_valid1 !== 1'b1 || req_ready1 !== 1'b0 || rom_en1 !== 1'b0) bad++;
            tick();
        end
        n_checks++;
        if (bad != 0) $display("FAIL bp_hold: %0d unstable cycles want 0", bad);
        else n_pass++;
        resp_ready = 1'b1;
        tick();
        resp_ready = 1'b0;
        n_checks++;
        if (req_ready1 !== 1'b1 || resp_valid1 !== 1'b0)
            $display("FAIL bp_release: ready=%b valid=%b want 1 0", req_ready1, resp_valid1);
        else n_pass++;
    endtask

    task automatic test_reset_mid();
        addr_bundle_t a;
        data_bundle_t e;
        int at12, lat;
        req_addr = ramp(0, 1);
        req_valid = 1'b1;
        tick();
        req_valid = 1'b0;
        at12 = -1;
        for (int c = 0; c < 40; c++) begin
            if (rom_en1 === 1'b1 && rom_addr1 === AW'(12)) begin at12 = c; break; end
            tick();
        end
        n_checks++;
        if (at12 != 12) $display("FAIL mid_reach12: got cycle %0d want 12", at12);
        else n_pass++;
        rst = 1'b1;
        #2;
        n_checks++;
        if (busy1 !== 1'b0 || req_ready1 !== 1'b1 || resp_valid1 !== 1'b0)
            $display("FAIL mid_reset_hs: busy=%b ready=%b valid=%b want 0 1 0", busy1, req_ready1, resp_valid1);
        else n_pass++;
        n_checks++;
        if (rom_en1 !== 1'b0 || rom_addr1 !== '0 || rom_sel1 !== '0 || resp_data1 !== '0)
            $display("FAIL mid_reset_rom: en=%b addr=%h sel=%h data=%h want all 0", rom_en1, rom_addr1, rom_sel1, resp_data1);
        else n_pass++;
        @(posedge clk);
        #1;
        rst = 1'b0;
        tick();
        a = ramp(32'h7FF, 0);
        for (int t = 0; t < TILES; t++)
            for (int l = 0; l < LANES; l++)
                e[t][l] = 11'h6AA;
        req_addr = a;
        req_valid = 1'b1;
        tick();
        req_valid = 1'b0;
        lat = -1;
        for (int c = 0; c < 60; c++) begin
            if (resp_valid1) begin lat = c; break; end
            tick();
        end
        n_checks++;
        if (lat != 33 || resp_data1 !== e)
            $display("FAIL mid_after: lat=%0d data=%h want 33 %h", lat, resp_data1, e);
        else n_pass++;
        resp_ready = 1'b1;
        tick();
        resp_ready = 1'b0;
    endtask

    task automatic test_lat3();
        addr_bundle_t a;
        data_bundle_t e;
        int lat, bad;
        a = ramp(0, 1);
        e = rom_of(a);
        req_addr = a;
        req_valid3 = 1'b1;
        tick();
        req_valid3 = 1'b0;
        lat = -1; bad = 0;
        for (int c = 0; c < 60; c++) begin
            if (c < 32 && (rom_en3 !== 1'b1 || rom_addr3 !== AW'(c))) bad++;
            if (resp_valid3) begin lat = c; break; end
            tick();
        end
        n_checks++;
        if (lat != 35 || bad != 0) $display("FAIL lat3_timing: lat=%0d bad=%0d want 35 0", lat, bad);
        else n_pass++;
        n_checks++;
        if (resp_data3 !== e) $display("FAIL lat3_data: got %h want %h", resp_data3, e);
        else n_pass++;
        resp_ready3 = 1'b1;
        tick();
        resp_ready3 = 1'b0;
        n_checks++;
        if (req_ready3 !== 1'b1 || resp_valid3 !== 1'b0)
            $display("FAIL lat3_done: ready=%b valid=%b want 1 0", req_ready3, resp_valid3);
        else n_pass++;
    endtask

    task automatic test_sel_latch();
        int lat, bad;
        req_addr = ramp(32'h123, 7);
        m1 = 5'h03; m2 = 5'h1C;
        req_valid = 1'b1;
        tick();
        req_valid = 1'b0;
        lat = -1; bad = 0;
        for (int c = 0; c < 60; c++) begin
            if (rom_sel1 !== 10'h07C) bad++;
            if (resp_valid1) begin lat = c; break; end
            if (c == 5) begin m1 = 5'h00; m2 = 5'h00; end
            tick();
        end
        n_checks++;
        if (bad != 0 || lat != 33) $display("FAIL sel_hold: bad=%0d lat=%0d want 0 33", bad, lat);
        else n_pass++;
        resp_ready = 1'b1;
        tick();
        resp_ready = 1'b0;
        n_checks++;
        if (rom_sel1 !== 10'h07C) $display("FAIL sel_idle: got %h want 07C", rom_sel1);
        else n_pass++;
    endtask

    task automatic test_back_to_back();
        addr_bundle_t a, b;
        data_bundle_t ea, eb;
        int lat;
        a = ramp(32'h100, 1);
        b = ramp(32'h600, 5);
        ea = rom_of(a);
        eb = rom_of(b);
        resp_ready = 1'b1;
        req_addr = a;
        req_valid = 1'b1;
        tick();
        req_addr = b;
        lat = -1;
        for (int c = 0; c < 60; c++) begin
            if (resp_valid1) begin lat = c; break; end
            tick();
        end
        n_checks++;
        if (lat != 33 || resp_data1 !== ea)
            $display("FAIL b2b_first: lat=%0d data=%h want 33 %h", lat, resp_data1, ea);
        else n_pass++;
        tick();
        n_checks++;
        if (req_ready1 !== 1'b1 || resp_valid1 !== 1'b0)
            $display("FAIL b2b_gap: ready=%b valid=%b want 1 0", req_ready1, resp_valid1);
        else n_pass++;
        tick();
        req_valid = 1'b0;
        n_checks++;
        if (busy1 !== 1'b1 || req_ready1 !== 1'b0 || rom_addr1 !== b[0][0])
            $display("FAIL b2b_accept: busy=%b ready=%b addr=%h want 1 0 %h", busy1, req_ready1, rom_addr1, b[0][0]);
        else n_pass++;
        lat = -1;
        for (int c = 0; c < 60; c++) begin
            if (resp_valid1) begin lat = c; break; end
            tick();
        end
        n_checks++;
        if (lat != 33 || resp_data1 !== eb)
            $display("FAIL b2b_second: lat=%0d data=%h want 33 %h", lat, resp_data1, eb);
        else n_pass++;
        tick();
        resp_ready = 1'b0;
        n_checks++;
        if (req_ready1 !== 1'b1 || busy1 !== 1'b0)
            $display("FAIL b2b_end: ready=%b busy=%b want 1 0", req_ready1, busy1);
        else n_pass++;
    endtask

    initial begin
        rst = 1'b1;
        req_valid = 1'b0; req_valid3 = 1'b0;
        resp_ready = 1'b0; resp_ready3 = 1'b0;
        req_addr = '0; m1 = '0; m2 = '0;
        test_reset();
        test_single();
        test_backpressure();
        test_reset_mid();
        test_lat3();
        test_sel_latch();
        test_back_to_back();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
